reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Write-hazard scoreboard that sequences access to the 8-entry register file.
- Tracks outstanding writes per register, counting instructions issued with dstE/dstM that have not yet reached write-back.
- Gates decode-stage issue with a ready/valid handshake whenever srcA/srcB hits a pending register or a destination counter would saturate.
- Sits beside the register file between the decode and write-back stages.

Parameters:
- REGNUM, 8: number of architectural registers tracked.
- ID_W, 4: register-ID width; matches the register-file srcA/srcB/dstE/dstM ports.
- NOREG, 15: ID meaning "no register". Any ID >= REGNUM is treated as NOREG.
- CNT_W, 2: per-register pending-counter width. Maximum outstanding writes per register is 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- issue_valid  in  1  decode stage presents an instruction
- issue_ready  out  1  instruction may issue this cycle
- issue_srcA  in  ID_W  source A register ID
- issue_srcB  in  ID_W  source B register ID
- issue_dstE  in  ID_W  E-port destination register ID
- issue_dstM  in  ID_W  M-port destination register ID
- wb_dstE  in  ID_W  write-back E destination; NOREG means idle
- wb_dstM  in  ID_W  write-back M destination; NOREG means idle
- flush  in  1  synchronous clear of all pending state (mispredict)
- busy  out  REGNUM  bit i = counter[i] != 0
- pending_total  out  ID_W+CNT_W  sum of all counters
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst=0, async):
  - All counters 0, err=0.
  - busy=0, pending_total=0, hence issue_ready=1.
- Valid IDs: an ID is valid when it is < REGNUM and != NOREG. Invalid IDs never hazard, never increment, never decrement.
- Hazard (combinational, from registered counters):
  - Occurs when a valid srcA or srcB has counter != 0.
  - dstE/dstM do not cause a hazard (WAW allowed, counted).
- Saturation:
  - Let inc[r] = number of valid issue dsts equal to r (0, 1 or 2; dstE==dstM counts 2).
  - Stall if any r has counter[r] + inc[r] > 2^CNT_W-1.
- issue_ready = !hazard && !saturation && !flush.
  - Depends on issue_* IDs, not on issue_valid.
- Fire = issue_valid && issue_ready.
  - On fire, counter[r] += inc[r] at the next rising edge.
- Retire:
  - dec[r] = number of valid wb dsts equal to r (0..2).
  - counter[r] -= dec[r] at the next edge.
- Simultaneous issue and retire on the same r: next = counter + inc - dec, applied in one update (net result, no ordering).
- Underflow (dec[r] > counter[r] + inc[r] on fire, or dec[r] > counter[r] otherwise):
  - counter[r] clamps to 0.
  - err set to 1; stays 1 until reset.
- Retire does not clear a hazard in the same cycle; the hazard drops the cycle after the write-back edge. This matches the register file, which writes at that edge and reads combinationally afterwards.
- flush=1:
  - All counters -> 0 at the next edge, overriding issue and retire that cycle.
  - issue_ready=0 during the flush cycle.
  - err is unaffected.
- pending_total and busy are combinational from the registered counters; 0 latency after the edge.
- Reset asserted mid-operation clears everything asynchronously; no partial state survives.

Optional Feature:
- Macro: SB_WB_BYPASS_EN
- Defined:
  - The hazard check for source r uses (counter[r] - dec[r]) instead of counter[r].
  - Same-cycle write-back releases the stall, so issue occurs in the write-back cycle. Decode must forward valE/valM.
  - The saturation check likewise uses counter - dec + inc.
- Undefined: behaviour as in Behaviour above; hazard clears one cycle after write-back.

Test Plan:
- Reset, then issue dstE=3 with issue_valid=1 -> next cycle busy=8'h08, pending_total=1, issue_ready=1 for srcA=srcB=NOREG.
- Counter[3]=1, present srcA=3; then wb_dstE=3 -> issue_ready=0 until the cycle after write-back. With SB_WB_BYPASS_EN, issue_ready=1 in the write-back cycle.
- Issue dstE=dstM=4 (popl %esp) -> counter[4]=2. Second identical issue -> issue_ready=0 (2+2>3). Retire wb_dstE=wb_dstM=4 -> counter[4]=0.
- Counter[1]=1; same cycle: issue dstE=1 fires and wb_dstE=1 -> counter[1] stays 1, err=0.
- wb_dstM=5 with counter[5]=0 -> err=1 sticky, counter[5]=0. Only rst low clears err.
- Counters {2:1, 6:3}, flush=1 with simultaneous issue_valid -> issue_ready=0; next cycle busy=0, pending_total=0.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// Decode-issue and write-back signal bundle for the register write-hazard scoreboard.
// The decode/write-back side drives through master; the scoreboard uses slave.
interface reg_scoreboard_if #(
   parameter int unsigned ID_W = 4
) ();
   logic            issue_valid;
   logic            issue_ready;
   logic [ID_W-1:0] issue_srcA;
   logic [ID_W-1:0] issue_srcB;
   logic [ID_W-1:0] issue_dstE;
   logic [ID_W-1:0] issue_dstM;
   logic [ID_W-1:0] wb_dstE;
   logic [ID_W-1:0] wb_dstM;

   modport master (
      output issue_valid, issue_srcA, issue_srcB, issue_dstE, issue_dstM,
      output wb_dstE, wb_dstM,
      input  issue_ready
   );

   modport slave (
      input  issue_valid, issue_srcA, issue_srcB, issue_dstE, issue_dstM,
      input  wb_dstE, wb_dstM,
      output issue_ready
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Write-hazard scoreboard: per-register pending-write counters gating decode issue.
// Optional macro SB_WB_BYPASS_EN lets a same-cycle write-back release hazards/saturation.
module reg_scoreboard #(
   parameter int unsigned REGNUM = 8,
   parameter int unsigned ID_W   = 4,
   parameter int unsigned NOREG  = 15,
   parameter int unsigned CNT_W  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   reg_scoreboard_if.slave        sb,
   input  logic                   flush,
   output logic [REGNUM-1:0]      busy,
   output logic [ID_W+CNT_W-1:0]  pending_total,
   output logic                   err
);
   localparam int unsigned SW   = CNT_W + 2;
   localparam int unsigned PW   = ID_W + CNT_W;
   localparam int unsigned CMAX = (1 << CNT_W) - 1;

   logic [REGNUM-1:0][CNT_W-1:0] cnt;
   logic [REGNUM-1:0][CNT_W-1:0] nxt;
   logic [REGNUM-1:0][1:0]       inc;
   logic [REGNUM-1:0][1:0]       dec;
   logic                         hazard;
   logic                         sat;
   logic                         ready;
   logic                         fire;
   logic                         uf;
   logic                         ok_a, ok_b, ok_e, ok_m, ok_we, ok_wm;
   logic [SW-1:0]                cnt_e, inc_e, dec_e, floor_e, tot_e;

   function automatic logic id_ok(input logic [ID_W-1:0] id);
      return (32'(id) < REGNUM) && (32'(id) != NOREG);
   endfunction

   always_comb begin
      ok_a  = id_ok(sb.issue_srcA);
      ok_b  = id_ok(sb.issue_srcB);
      ok_e  = id_ok(sb.issue_dstE);
      ok_m  = id_ok(sb.issue_dstM);
      ok_we = id_ok(sb.wb_dstE);
      ok_wm = id_ok(sb.wb_dstM);
   end

   always_comb begin
      hazard  = 1'b0;
      sat     = 1'b0;
      inc     = '0;
      dec     = '0;
      cnt_e   = '0;
      inc_e   = '0;
      dec_e   = '0;
      floor_e = '0;
      for (int unsigned r = 0; r < REGNUM; r++) begin
         inc[r] = 2'(ok_e && (32'(sb.issue_dstE) == r)) + 2'(ok_m && (32'(sb.issue_dstM) == r));
         dec[r] = 2'(ok_we && (32'(sb.wb_dstE) == r)) + 2'(ok_wm && (32'(sb.wb_dstM) == r));
         cnt_e  = SW'(cnt[r]);
         inc_e  = SW'(inc[r]);
         dec_e  = SW'(dec[r]);
`ifdef SB_WB_BYPASS_EN
         floor_e = dec_e;
`else
         floor_e = '0;
`endif
         // Both checks are written additively so (counter - dec) never goes negative.
         if (((ok_a && (32'(sb.issue_srcA) == r)) || (ok_b && (32'(sb.issue_srcB) == r)))
             && (cnt_e > floor_e))
            hazard = 1'b1;
         if (cnt_e + inc_e > SW'(CMAX) + floor_e)
            sat = 1'b1;
      end
      ready = !hazard && !sat && !flush;
      fire  = sb.issue_valid && ready;
   end

   assign sb.issue_ready = ready;

   always_comb begin
      nxt   = '0;
      uf    = 1'b0;
      tot_e = '0;
      for (int unsigned r = 0; r < REGNUM; r++) begin
         tot_e = SW'(cnt[r]) + (fire ? SW'(inc[r]) : SW'(0));
         if (SW'(dec[r]) > tot_e) begin
            nxt[r] = '0;
            uf     = 1'b1;
         end else begin
            nxt[r] = CNT_W'(tot_e - SW'(dec[r]));
         end
      end
   end

   always_comb begin
      busy          = '0;
      pending_total = '0;
      for (int unsigned r = 0; r < REGNUM; r++) begin
         busy[r]       = (cnt[r] != '0);
         pending_total = pending_total + PW'(cnt[r]);
      end
   end

   // Flush discards that cycle's issue and retire entirely, so it cannot raise err.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         err <= 1'b0;
      end else if (flush) begin
         cnt <= '0;
      end else begin
         cnt <= nxt;
         if (uf)
            err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed cycles push expectations, a monitor compares.
module tb_reg_scoreboard;
   localparam logic [3:0] N = 4'd15;

   typedef struct {
      string      name;
      logic       rdy;
      logic [7:0] busy;
      logic [5:0] pt;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] busy;
   logic [5:0] pending_total;
   logic       err;
   int         total = 0;
   int         bad = 0;
   exp_t       q[$];

   reg_scoreboard_if #(.ID_W(4)) sbi ();

   reg_scoreboard #(.REGNUM(8), .ID_W(4), .NOREG(15), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .sb(sbi), .flush(flush),
      .busy(busy), .pending_total(pending_total), .err(err)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge, away from the rising edge that updates state.
   task automatic cyc(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] e, input logic [3:0] m, input logic [3:0] we,
                      input logic [3:0] wm, input logic fl);
      @(negedge clk);
      rst              = r;
      sbi.issue_valid  = v;
      sbi.issue_srcA   = a;
      sbi.issue_srcB   = b;
      sbi.issue_dstE   = e;
      sbi.issue_dstM   = m;
      sbi.wb_dstE      = we;
      sbi.wb_dstM      = wm;
      flush            = fl;
   endtask

   task automatic expect_now(input string name, input logic rdy, input logic [7:0] bz,
                             input logic [5:0] pt, input logic er);
      exp_t x;
      x.name = name; x.rdy = rdy; x.busy = bz; x.pt = pt; x.err = er;
      q.push_back(x);
   endtask

   always begin
      @(negedge clk);
      #3;
      while (q.size() > 0) begin
         exp_t x;
         x = q.pop_front();
         total++;
         if (sbi.issue_ready !== x.rdy || busy !== x.busy || pending_total !== x.pt || err !== x.err) begin
            bad++;
            $display("FAIL %s: got rdy=%b busy=%h pt=%0d err=%b want rdy=%b busy=%h pt=%0d err=%b",
                     x.name, sbi.issue_ready, busy, pending_total, err, x.rdy, x.busy, x.pt, x.err);
         end
      end
   end

   initial begin
      sbi.issue_valid = 1'b0;
      sbi.issue_srcA = N; sbi.issue_srcB = N; sbi.issue_dstE = N; sbi.issue_dstM = N;
      sbi.wb_dstE = N; sbi.wb_dstM = N;

      cyc(0, 0, N, N, N, N, N, N, 0); expect_now("reset",         1, 8'h00, 0, 0);
      cyc(1, 1, N, N, 3, N, N, N, 0); expect_now("issue_e3",      1, 8'h00, 0, 0);
      cyc(1, 0, N, N, N, N, N, N, 0); expect_now("after_e3",      1, 8'h08, 1, 0);
      cyc(1, 1, 3, N, N, N, N, N, 0); expect_now("hazard_a3",     0, 8'h08, 1, 0);
      cyc(1, 1, 3, N, N, N, 3, N, 0);
`ifdef SB_WB_BYPASS_EN
      expect_now("wb_cycle_a3", 1, 8'h08, 1, 0);
`else
      expect_now("wb_cycle_a3", 0, 8'h08, 1, 0);
`endif
      cyc(1, 0, 3, N, N, N, N, N, 0); expect_now("after_wb3",     1, 8'h00, 0, 0);
      cyc(1, 1, N, N, 4, 4, N, N, 0); expect_now("issue_em4",     1, 8'h00, 0, 0);
      cyc(1, 1, N, N, 4, 4, N, N, 0); expect_now("sat_2p2",       0, 8'h10, 2, 0);
      cyc(1, 1, N, N, 4, N, N, N, 0); expect_now("fill_2p1",      1, 8'h10, 2, 0);
      cyc(1, 1, N, N, 4, N, N, N, 0); expect_now("sat_3p1",       0, 8'h10, 3, 0);
      cyc(1, 0, N, N, N, N, 4, 4, 0); expect_now("wb_em4",        1, 8'h10, 3, 0);
      cyc(1, 0, N, N, N, N, 4, N, 0); expect_now("wb_e4",         1, 8'h10, 1, 0);
      cyc(1, 1, N, N, 1, N, N, N, 0); expect_now("issue_e1",      1, 8'h00, 0, 0);
      cyc(1, 1, N, N, 1, N, 1, N, 0); expect_now("issue_wb_e1",   1, 8'h02, 1, 0);
      cyc(1, 0, N, 1, N, N, N, 5, 0); expect_now("hazard_b1_uf5", 0, 8'h02, 1, 0);
      cyc(1, 0, N, N, N, N, 1, N, 0); expect_now("err_sticky",    1, 8'h02, 1, 1);
      cyc(1, 1, N, N, 2, N, N, N, 0); expect_now("issue_e2",      1, 8'h00, 0, 1);
      cyc(1, 1, N, N, 6, 6, N, N, 0); expect_now("issue_em6",     1, 8'h04, 1, 1);
      cyc(1, 1, N, N, 6, N, N, N, 0); expect_now("issue_e6",      1, 8'h44, 3, 1);
      cyc(1, 1, N, N, 0, N, 2, N, 1); expect_now("flush_cycle",   0, 8'h44, 4, 1);
      cyc(1, 0, N, N, N, N, N, N, 0); expect_now("after_flush",   1, 8'h00, 0, 1);
      cyc(1, 1, 9, 8, 8, N, 12, N, 0); expect_now("invalid_ids",  1, 8'h00, 0, 1);
      cyc(1, 0, N, N, N, N, N, N, 0); expect_now("after_invalid", 1, 8'h00, 0, 1);
      cyc(1, 1, N, N, 7, N, N, N, 0); expect_now("issue_e7",      1, 8'h00, 0, 1);
      cyc(1, 0, N, N, N, N, N, N, 0); expect_now("before_rst",    1, 8'h80, 1, 1);
      cyc(0, 1, N, N, 7, N, N, N, 0); expect_now("async_rst",     1, 8'h00, 0, 0);
      cyc(1, 0, N, N, N, N, N, N, 0); expect_now("after_rst",     1, 8'h00, 0, 0);

      @(negedge clk);
      #5;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no completion want finish before 20000");
      $fatal(1, "timeout");
   end
endmodule
